fp16_seq_divider: RTL and testbench

//  Iterative IEEE-754 binary16 divider, out = A / B. Inverse operation of fp16multiplier, same number handling:
//   - subnormals flushed to zero
//   - canonical NaN
//   - round-to-nearest-even

---
 rtl/fp16_seq_divider.sv | 145 ++++++++++++++
 tb/tb_fp16_seq_divider.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp16_seq_divider.sv
// Iterative binary16 divider: restoring radix-2, one quotient bit per cycle.
// Subnormals flush to zero, NaN results are canonical, rounding is nearest-even.
module fp16_seq_divider #(
    parameter int          QBITS   = 13,
    parameter logic [14:0] NAN_MAG = 15'h7C01
) (
    input  logic        CLK,
    input  logic        RESETn,
    input  logic        start,
    input  logic [15:0] A,
    input  logic [15:0] B,
    output logic        busy,
    output logic        done,
    output logic [15:0] out
);

    typedef enum logic [2:0] {IDLE, PREP, DIV, ROUND, FIN} state_t;

    localparam logic [3:0] LAST = 4'(QBITS - 1);

    state_t             state;
    logic        [15:0] a_q, b_q;
    logic        [11:0] rem;
    logic        [10:0] m_b;
    logic   [QBITS-1:0] q;
    logic         [3:0] cnt;
    logic signed  [6:0] e;
    logic        [15:0] res;

    logic        sgn, a_zero, a_inf, a_nan, b_zero, b_inf, b_nan;
    logic        spec_nan, spec_inf, spec_zero, ma_lt;
    logic [10:0] ma, mb;
    logic signed [6:0]  e_raw;
    logic signed [12:0] t;

    assign sgn    = a_q[15] ^ b_q[15];
    assign a_zero = (a_q[14:10] == 5'd0);
    assign a_inf  = (a_q[14:10] == 5'h1F) && (a_q[9:0] == 10'd0);
    assign a_nan  = (a_q[14:10] == 5'h1F) && (a_q[9:0] != 10'd0);
    assign b_zero = (b_q[14:10] == 5'd0);
    assign b_inf  = (b_q[14:10] == 5'h1F) && (b_q[9:0] == 10'd0);
    assign b_nan  = (b_q[14:10] == 5'h1F) && (b_q[9:0] != 10'd0);

    // Evaluated in priority order: NaN, then infinity, then zero.
    assign spec_nan  = a_nan | b_nan | (a_zero & b_zero) | (a_inf & b_inf);
    assign spec_inf  = a_inf | b_zero;
    assign spec_zero = a_zero | b_inf;

    assign ma    = {1'b1, a_q[9:0]};
    assign mb    = {1'b1, b_q[9:0]};
    assign ma_lt = (ma < mb);
    assign e_raw = $signed({2'b00, a_q[14:10]}) - $signed({2'b00, b_q[14:10]}) + 7'sd15;

    assign t = $signed({1'b0, rem}) - $signed({2'b00, m_b});

    function automatic logic [15:0] round_result(input logic s,
                                                 input logic signed [6:0] ex,
                                                 input logic [12:0] qq,
                                                 input logic sticky);
        logic              up;
        logic       [11:0] m11;
        logic signed [6:0] en;
        logic        [9:0] man;
        logic       [15:0] r;
        up  = qq[1] & (qq[0] | sticky | qq[2]);
        m11 = {1'b0, qq[12:2]} + {11'd0, up};
        // qq[12] is always set, so bit 10 clears only when rounding carries into bit 11.
        man = m11[10] ? m11[9:0] : 10'd0;
        en  = ex + $signed({6'd0, m11[11]});
        if (en >= 7'sd31)
            r = {s, 15'h7C00};
        else if (en <= 7'sd0)
            r = {s, 15'h0000};
        else
            r = {s, en[4:0], man};
        return r;
    endfunction

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            out   <= 16'h0000;
            a_q   <= 16'h0000;
            b_q   <= 16'h0000;
            rem   <= 12'd0;
            m_b   <= 11'd0;
            q     <= '0;
            cnt   <= 4'd0;
            e     <= 7'sd0;
            res   <= 16'h0000;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_q   <= A;
                        b_q   <= B;
                        busy  <= 1'b1;
                        state <= PREP;
                    end
                end
                PREP: begin
                    q   <= '0;
                    cnt <= 4'd0;
                    m_b <= mb;
                    if (spec_nan) begin
                        res   <= {sgn, NAN_MAG};
                        state <= FIN;
                    end else if (spec_inf) begin
                        res   <= {sgn, 15'h7C00};
                        state <= FIN;
                    end else if (spec_zero) begin
                        res   <= {sgn, 15'h0000};
                        state <= FIN;
                    end else begin
                        rem   <= ma_lt ? {ma, 1'b0} : {1'b0, ma};
                        e     <= ma_lt ? e_raw - 7'sd1 : e_raw;
                        state <= DIV;
                    end
                end
                DIV: begin
                    q   <= {q[QBITS-2:0], ~t[12]};
                    rem <= t[12] ? (rem << 1) : (t[11:0] << 1);
                    cnt <= cnt + 4'd1;
                    if (cnt == LAST)
                        state <= ROUND;
                end
                ROUND: begin
                    res   <= round_result(sgn, e, q, rem != 12'd0);
                    state <= FIN;
                end
                FIN: begin
                    out   <= res;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fp16_seq_divider.sv
// Scoreboard bench for fp16_seq_divider: an integer-arithmetic reference predicts
// each quotient and its done cycle; a monitor pops and compares on every done pulse.
module tb_fp16_seq_divider;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] a_in, b_in;
    logic        busy, done;
    logic [15:0] quo;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [15:0] exp_q[$];
    int          cyc_q[$];
    logic        done_prev = 1'b0;

    fp16_seq_divider dut (
        .CLK(clk), .RESETn(rst_n), .start(start), .A(a_in), .B(b_in),
        .busy(busy), .done(done), .out(quo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] model_div(input logic [15:0] a, input logic [15:0] b);
        int ea, eb, fa, fb, num, qv, r, ex, sh, keep, low, half;
        logic s, az, ai, an, bz, bi, bn;
        s  = a[15] ^ b[15];
        ea = int'(a[14:10]); eb = int'(b[14:10]);
        fa = int'(a[9:0]);   fb = int'(b[9:0]);
        az = (ea == 0); ai = (ea == 31 && fa == 0); an = (ea == 31 && fa != 0);
        bz = (eb == 0); bi = (eb == 31 && fb == 0); bn = (eb == 31 && fb != 0);
        if (an || bn || (az && bz) || (ai && bi)) return {s, 15'h7C01};
        if (ai || bz) return {s, 15'h7C00};
        if (az || bi) return {s, 15'h0000};
        num = (1024 + fa) << 13;
        qv  = num / (1024 + fb);
        r   = num % (1024 + fb);
        ex  = ea - eb + 15;
        if (qv >= 8192) sh = 3;
        else begin sh = 2; ex = ex - 1; end
        keep = qv >> sh;
        low  = qv & ((1 << sh) - 1);
        half = 1 << (sh - 1);
        if (low > half || (low == half && (r != 0 || (keep % 2) == 1))) keep = keep + 1;
        if (keep == 2048) begin keep = 1024; ex = ex + 1; end
        if (ex >= 31) return {s, 15'h7C00};
        if (ex <= 0)  return {s, 15'h0000};
        return {s, 5'(ex), 10'(keep)};
    endfunction

    function automatic int model_lat(input logic [15:0] a, input logic [15:0] b);
        if (a[14:10] == 5'd0 || a[14:10] == 5'h1F || b[14:10] == 5'd0 || b[14:10] == 5'h1F)
            return 2;
        return 16;
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            if (done) begin
                checks++;
                if (done_prev) begin
                    errors++;
                    $display("FAIL done_width: done high %0d cycles, expected 1", 2);
                end
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: out=%h at cycle %0d, none expected", quo, cyc);
                end else begin
                    logic [15:0] e_out;
                    int          e_cyc;
                    e_out = exp_q.pop_front();
                    e_cyc = cyc_q.pop_front();
                    checks++;
                    if (quo !== e_out) begin
                        errors++;
                        $display("FAIL result: out=%h expected %h", quo, e_out);
                    end
                    checks++;
                    if (cyc !== e_cyc) begin
                        errors++;
                        $display("FAIL latency: done at cycle %0d expected %0d", cyc, e_cyc);
                    end
                end
            end
            done_prev <= done;
        end else begin
            done_prev <= 1'b0;
        end
    end

    task automatic issue(input logic [15:0] a, input logic [15:0] b);
        int k;
        @(negedge clk);
        a_in = a; b_in = b; start = 1'b1;
        @(posedge clk); #1;
        k = cyc;
        start = 1'b0;
        a_in = 16'($urandom); b_in = 16'($urandom);
        exp_q.push_back(model_div(a, b));
        cyc_q.push_back(k + model_lat(a, b));
    endtask

    task automatic drain();
        for (int i = 0; i < 80 && exp_q.size() != 0; i++) @(negedge clk);
        @(negedge clk);
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d results still pending, expected 0", exp_q.size());
            exp_q.delete();
            cyc_q.delete();
        end
    endtask

    task automatic run_op(input logic [15:0] a, input logic [15:0] b);
        issue(a, b);
        drain();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; a_in = 16'h0; b_in = 16'h0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({busy, done, quo} !== 18'h0) begin
            errors++;
            $display("FAIL reset_state: busy=%b done=%b out=%h expected 0 0 0000", busy, done, quo);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_latency();
        @(negedge clk);
        a_in = 16'h3C00; b_in = 16'h3C00; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        exp_q.push_back(16'h3C00);
        cyc_q.push_back(cyc + 16);
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (busy !== 1'b1 || done !== 1'b0) begin
                errors++;
                $display("FAIL busy_window: step %0d busy=%b done=%b expected 1 0", i, busy, done);
            end
            @(posedge clk); #1;
        end
        checks++;
        if (busy !== 1'b0 || done !== 1'b1) begin
            errors++;
            $display("FAIL done_edge: busy=%b done=%b expected 0 1", busy, done);
        end
        drain();
    endtask

    task automatic test_normal();
        run_op(16'h4000, 16'h4200);
        run_op(16'hC000, 16'h4200);
        run_op(16'h3C00, 16'h4000);
    endtask

    task automatic test_specials();
        run_op(16'h3C00, 16'h0000);
        run_op(16'hBC00, 16'h0000);
        run_op(16'h0000, 16'h0000);
        run_op(16'h7C00, 16'h7C00);
        run_op(16'h7E00, 16'h3C00);
        run_op(16'h0000, 16'h4000);
        run_op(16'h4000, 16'h7C00);
        run_op(16'h0001, 16'h3C00);
        run_op(16'h8000, 16'h7E00);
    endtask

    task automatic test_range();
        run_op(16'h7BFF, 16'h1400);
        run_op(16'h0400, 16'h4000);
        run_op(16'h3BFF, 16'h3800);
        run_op(16'h3BFF, 16'h3BFE);
        run_op(16'h3C00, 16'h3BFF);
    endtask

    task automatic test_random();
        for (int i = 0; i < 200; i++) begin
            logic [15:0] a, b;
            a = 16'($urandom);
            b = 16'($urandom);
            if ($urandom_range(0, 9) == 0) a[14:10] = ($urandom_range(0, 1) == 0) ? 5'd0 : 5'h1F;
            if ($urandom_range(0, 9) == 0) b[14:10] = ($urandom_range(0, 1) == 0) ? 5'd0 : 5'h1F;
            run_op(a, b);
        end
    endtask

    task automatic test_back_to_back();
        int k;
        @(negedge clk);
        a_in = 16'h3C00; b_in = 16'h4000; start = 1'b1;
        @(posedge clk); #1;
        k = cyc;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(16'h3800);
            cyc_q.push_back(k + 16 + 17 * i);
        end
        repeat (39) @(posedge clk);
        #1;
        start = 1'b0;
        drain();
    endtask

    task automatic test_reset_abort();
        bit saw_done;
        @(negedge clk);
        a_in = 16'h3C00; b_in = 16'h3C00; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, quo} !== 18'h0) begin
            errors++;
            $display("FAIL abort_state: busy=%b done=%b out=%h expected 0 0 0000", busy, done, quo);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        saw_done = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        checks++;
        if (saw_done !== 1'b0) begin
            errors++;
            $display("FAIL abort_no_done: saw done=%b expected 0", saw_done);
        end
        run_op(16'h4400, 16'h4000);
    endtask

    initial begin
        test_reset();
        test_latency();
        test_normal();
        test_specials();
        test_range();
        test_random();
        test_back_to_back();
        test_reset_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
